// File: rtl/egg_timer_ctrl.sv
// egg_timer_ctrl: egg-timer control block.
//
// Captures a BCD mm:ss preset from SW, counts it down once per TICKS_PER_SEC
// clocks and flashes an alarm at 00:00.
//
// Ports:
//   CLOCK_50  in   system clock, rising edge
//   RESET_N   in   asynchronous active-low reset
//   KEY[2:0]  in   raw active-low buttons: [0] clear, [1] set/advance, [2] start/pause
//   SW[7:0]   in   BCD preset, [7:4] tens digit, [3:0] units digit
//   state     out  current state code (bit 3 always 0)
//   MIN_BCD   out  minutes, two BCD digits
//   SEC_BCD   out  seconds, two BCD digits
//   ALARM     out  high only while in FLASH_ON
module egg_timer_ctrl #(
    parameter int unsigned TICKS_PER_SEC = 50000000,
    parameter int unsigned FLASH_TICKS   = 12500000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [2:0] KEY,
    input  logic [7:0] SW,
    output logic [3:0] state,
    output logic [7:0] MIN_BCD,
    output logic [7:0] SEC_BCD,
    output logic       ALARM
);

    typedef enum logic [3:0] {
        StSetSec   = 4'd0,
        StSetMin   = 4'd1,
        StTimer    = 4'd2,
        StReady    = 4'd3,
        StReset    = 4'd4,
        StFlashOn  = 4'd5,
        StFlashOff = 4'd6
    } state_e;

    localparam int unsigned TickW  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned FlashW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
    localparam logic [TickW-1:0]  TickLast  = TickW'(TICKS_PER_SEC - 1);
    localparam logic [FlashW-1:0] FlashLast = FlashW'(FLASH_TICKS - 1);

    // Plain vector so that codes outside the enum (e.g. 7) are representable
    // and recovered through the default branch.
    logic [3:0]        state_q;
    logic [7:0]        min_q;
    logic [7:0]        sec_q;
    logic              alarm_q;
    logic [TickW-1:0]  tick_q;
    logic [FlashW-1:0] flash_q;

    logic [2:0] key_meta_q;
    logic [2:0] key_sync_q;
    logic [2:0] key_prev_q;

    logic [2:0] key_fall;
    logic       ev_clear;
    logic       ev_set;
    logic       ev_start;

    logic [7:0] sec_clamped;
    logic [7:0] min_clamped;
    logic [7:0] dec_min;
    logic [7:0] dec_sec;
    logic       dec_zero;
    logic       count_zero;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // Two-flop synchronizer plus history flop per key; released level is 1.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            key_meta_q <= 3'b111;
            key_sync_q <= 3'b111;
            key_prev_q <= 3'b111;
        end else begin
            key_meta_q <= KEY;
            key_sync_q <= key_meta_q;
            key_prev_q <= key_sync_q;
        end
    end

    // Priority-encode: only the highest-priority event in a cycle is seen.
    always_comb begin
        key_fall = key_prev_q & ~key_sync_q;
        ev_clear = key_fall[0];
        ev_set   = key_fall[1] & ~key_fall[0];
        ev_start = key_fall[2] & ~key_fall[1] & ~key_fall[0];
    end

    always_comb begin
        sec_clamped = {clamp_digit(SW[7:4], 4'd5), clamp_digit(SW[3:0], 4'd9)};
        min_clamped = {clamp_digit(SW[7:4], 4'd9), clamp_digit(SW[3:0], 4'd9)};
    end

    // One-second BCD decrement; ss=00 borrows from the minutes.
    always_comb begin
        dec_min = min_q;
        dec_sec = sec_q;
        if (sec_q[3:0] != 4'd0) begin
            dec_sec[3:0] = sec_q[3:0] - 4'd1;
        end else if (sec_q[7:4] != 4'd0) begin
            dec_sec = {sec_q[7:4] - 4'd1, 4'd9};
        end else begin
            dec_sec = 8'h59;
            if (min_q[3:0] != 4'd0) begin
                dec_min[3:0] = min_q[3:0] - 4'd1;
            end else begin
                dec_min = {min_q[7:4] - 4'd1, 4'd9};
            end
        end
        dec_zero   = (dec_min == 8'h00) && (dec_sec == 8'h00);
        count_zero = (min_q == 8'h00) && (sec_q == 8'h00);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= StReset;
            min_q   <= 8'h00;
            sec_q   <= 8'h00;
            alarm_q <= 1'b0;
            tick_q  <= '0;
            flash_q <= '0;
        end else begin
            alarm_q <= 1'b0;
            if (ev_clear) begin
                state_q <= StReset;
                min_q   <= 8'h00;
                sec_q   <= 8'h00;
            end else begin
                case (state_q)
                    StReset: begin
                        min_q   <= 8'h00;
                        sec_q   <= 8'h00;
                        state_q <= StSetSec;
                    end
                    StSetSec: begin
                        sec_q <= sec_clamped;
                        if (ev_set) state_q <= StSetMin;
                    end
                    StSetMin: begin
                        min_q <= min_clamped;
                        if (ev_set) state_q <= StReady;
                    end
                    StReady: begin
                        if (ev_set) begin
                            state_q <= StSetSec;
                        end else if (ev_start) begin
                            if (count_zero) begin
                                state_q <= StFlashOn;
                                flash_q <= '0;
                                alarm_q <= 1'b1;
                            end else begin
                                state_q <= StTimer;
                                tick_q  <= '0;
                            end
                        end
                    end
                    StTimer: begin
                        if (ev_start) begin
                            state_q <= StReady;
                        end else if (tick_q == TickLast) begin
                            tick_q <= '0;
                            min_q  <= dec_min;
                            sec_q  <= dec_sec;
                            if (dec_zero) begin
                                state_q <= StFlashOn;
                                flash_q <= '0;
                                alarm_q <= 1'b1;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                    StFlashOn: begin
                        if (ev_set || ev_start) begin
                            state_q <= StReset;
                        end else if (flash_q == FlashLast) begin
                            flash_q <= '0;
                            state_q <= StFlashOff;
                        end else begin
                            flash_q <= flash_q + 1'b1;
                            alarm_q <= 1'b1;
                        end
                    end
                    StFlashOff: begin
                        if (ev_set || ev_start) begin
                            state_q <= StReset;
                        end else if (flash_q == FlashLast) begin
                            flash_q <= '0;
                            state_q <= StFlashOn;
                            alarm_q <= 1'b1;
                        end else begin
                            flash_q <= flash_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StReset;
                        min_q   <= 8'h00;
                        sec_q   <= 8'h00;
                    end
                endcase
            end
        end
    end

    assign state   = state_q;
    assign MIN_BCD = min_q;
    assign SEC_BCD = sec_q;
    assign ALARM   = alarm_q;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Directed testbench for egg_timer_ctrl with TICKS_PER_SEC=4, FLASH_TICKS=3.
module tb_egg_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] KEY = 3'b111;
    logic [7:0] SW = 8'h00;
    logic [3:0] state;
    logic [7:0] MIN_BCD;
    logic [7:0] SEC_BCD;
    logic       ALARM;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    egg_timer_ctrl #(
        .TICKS_PER_SEC(4),
        .FLASH_TICKS  (3)
    ) dut (
        .CLOCK_50(clk),
        .RESET_N (rst_n),
        .KEY     (KEY),
        .SW      (SW),
        .state   (state),
        .MIN_BCD (MIN_BCD),
        .SEC_BCD (SEC_BCD),
        .ALARM   (ALARM)
    );

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stimulus only: full press, state change lands on the 3rd negedge.
    task automatic press(input logic [1:0] b);
        KEY[b] = 1'b0;
        wait_neg(3);
        KEY[b] = 1'b1;
        wait_neg(2);
    endtask

    // From SET_SEC, load mm:ss and advance to READY.
    task automatic load_preset(input logic [7:0] m, input logic [7:0] s);
        SW = s;
        wait_neg(2);
        press(2'd1);
        SW = m;
        wait_neg(2);
        press(2'd1);
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #2;
        checks++; if (state !== 4'd4) begin
            errors++; $display("FAIL reset_state: got %0d expected 4", state); end
        checks++; if (MIN_BCD !== 8'h00 || SEC_BCD !== 8'h00) begin
            errors++; $display("FAIL reset_count: got %h:%h expected 00:00", MIN_BCD, SEC_BCD); end
        checks++; if (ALARM !== 1'b0) begin
            errors++; $display("FAIL reset_alarm: got %b expected 0", ALARM); end
        wait_neg(2);
        rst_n = 1'b1;
        wait_neg(1);
        checks++; if (state !== 4'd0) begin
            errors++; $display("FAIL reset_release: got %0d expected 0", state); end
    endtask

    task automatic test_clamp;
        SW = 8'hF7;
        wait_neg(1);
        checks++; if (SEC_BCD !== 8'h57) begin
            errors++; $display("FAIL clamp_sec_f7: got %h expected 57", SEC_BCD); end
        KEY[1] = 1'b0;
        wait_neg(2);
        checks++; if (state !== 4'd0) begin
            errors++; $display("FAIL key_latency_early: got %0d expected 0", state); end
        wait_neg(1);
        checks++; if (state !== 4'd1) begin
            errors++; $display("FAIL key_latency_set_min: got %0d expected 1", state); end
        KEY[1] = 1'b1;
        wait_neg(1);
        checks++; if (MIN_BCD !== 8'h97 || SEC_BCD !== 8'h57) begin
            errors++; $display("FAIL clamp_min_f7: got %h:%h expected 97:57", MIN_BCD, SEC_BCD); end
        wait_neg(1);
        press(2'd1);
        checks++; if (state !== 4'd3) begin
            errors++; $display("FAIL to_ready: got %0d expected 3", state); end
        press(2'd1);
        checks++; if (state !== 4'd0) begin
            errors++; $display("FAIL ready_to_set_sec: got %0d expected 0", state); end
        SW = 8'h7C;
        wait_neg(1);
        checks++; if (SEC_BCD !== 8'h59) begin
            errors++; $display("FAIL clamp_sec_7c: got %h expected 59", SEC_BCD); end
        press(2'd1);
        SW = 8'h02;
        wait_neg(1);
        checks++; if (MIN_BCD !== 8'h02 || SEC_BCD !== 8'h59) begin
            errors++; $display("FAIL set_min_02: got %h:%h expected 02:59", MIN_BCD, SEC_BCD); end
        KEY[1] = 1'b0;
        wait_neg(2);
        checks++; if (state !== 4'd1) begin
            errors++; $display("FAIL key_latency_early2: got %0d expected 1", state); end
        wait_neg(1);
        checks++; if (state !== 4'd3) begin
            errors++; $display("FAIL key_latency_ready: got %0d expected 3", state); end
        KEY[1] = 1'b1;
        wait_neg(4);
        checks++; if (state !== 4'd3 || MIN_BCD !== 8'h02 || SEC_BCD !== 8'h59) begin
            errors++; $display("FAIL ready_hold: got %0d %h:%h expected 3 02:59",
                               state, MIN_BCD, SEC_BCD); end
    endtask

    task automatic test_wrap_expiry;
        press(2'd1);
        load_preset(8'h01, 8'h00);
        checks++; if (state !== 4'd3 || MIN_BCD !== 8'h01 || SEC_BCD !== 8'h00) begin
            errors++; $display("FAIL preset_0100: got %0d %h:%h expected 3 01:00",
                               state, MIN_BCD, SEC_BCD); end
        KEY[2] = 1'b0;
        wait_neg(3);
        checks++; if (state !== 4'd2) begin
            errors++; $display("FAIL timer_entry: got %0d expected 2", state); end
        KEY[2] = 1'b1;
        wait_neg(3);
        checks++; if (MIN_BCD !== 8'h01 || SEC_BCD !== 8'h00) begin
            errors++; $display("FAIL pre_first_dec: got %h:%h expected 01:00", MIN_BCD, SEC_BCD); end
        wait_neg(1);
        checks++; if (MIN_BCD !== 8'h00 || SEC_BCD !== 8'h59) begin
            errors++; $display("FAIL wrap_0059: got %h:%h expected 00:59", MIN_BCD, SEC_BCD); end
        wait_neg(235);
        checks++; if (state !== 4'd2 || MIN_BCD !== 8'h00 || SEC_BCD !== 8'h01) begin
            errors++; $display("FAIL at_239: got %0d %h:%h expected 2 00:01",
                               state, MIN_BCD, SEC_BCD); end
        wait_neg(1);
        checks++; if (state !== 4'd5 || MIN_BCD !== 8'h00 || SEC_BCD !== 8'h00 || ALARM !== 1'b1)
        begin
            errors++; $display("FAIL expiry_240: got %0d %h:%h alarm=%b expected 5 00:00 alarm=1",
                               state, MIN_BCD, SEC_BCD, ALARM); end
        wait_neg(2);
        checks++; if (state !== 4'd5) begin
            errors++; $display("FAIL flash_on_hold: got %0d expected 5", state); end
        wait_neg(1);
        checks++; if (state !== 4'd6 || ALARM !== 1'b0) begin
            errors++; $display("FAIL flash_off: got %0d alarm=%b expected 6 alarm=0", state, ALARM);
        end
        wait_neg(3);
        checks++; if (state !== 4'd5 || ALARM !== 1'b1) begin
            errors++; $display("FAIL flash_on_again: got %0d alarm=%b expected 5 alarm=1",
                               state, ALARM); end
        KEY[1] = 1'b0;
        wait_neg(3);
        checks++; if (state !== 4'd4) begin
            errors++; $display("FAIL flash_key1_reset: got %0d expected 4", state); end
        KEY[1] = 1'b1;
        wait_neg(1);
        checks++; if (state !== 4'd0 || MIN_BCD !== 8'h00 || SEC_BCD !== 8'h00) begin
            errors++; $display("FAIL after_flash_reset: got %0d %h:%h expected 0 00:00",
                               state, MIN_BCD, SEC_BCD); end
        wait_neg(1);
    endtask

    task automatic test_pause_resume;
        load_preset(8'h00, 8'h10);
        KEY[2] = 1'b0;
        wait_neg(3);
        KEY[2] = 1'b1;
        wait_neg(3);
        checks++; if (state !== 4'd2 || SEC_BCD !== 8'h10) begin
            errors++; $display("FAIL pause_pre: got %0d %h expected 2 10", state, SEC_BCD); end
        KEY[2] = 1'b0;
        wait_neg(1);
        checks++; if (SEC_BCD !== 8'h09) begin
            errors++; $display("FAIL pause_first_dec: got %h expected 09", SEC_BCD); end
        wait_neg(2);
        checks++; if (state !== 4'd3 || SEC_BCD !== 8'h09) begin
            errors++; $display("FAIL paused: got %0d %h expected 3 09", state, SEC_BCD); end
        KEY[2] = 1'b1;
        wait_neg(10);
        checks++; if (state !== 4'd3 || SEC_BCD !== 8'h09) begin
            errors++; $display("FAIL pause_hold: got %0d %h expected 3 09", state, SEC_BCD); end
        KEY[2] = 1'b0;
        wait_neg(3);
        checks++; if (state !== 4'd2) begin
            errors++; $display("FAIL resume: got %0d expected 2", state); end
        KEY[2] = 1'b1;
        wait_neg(3);
        checks++; if (SEC_BCD !== 8'h09) begin
            errors++; $display("FAIL resume_partial_discard: got %h expected 09", SEC_BCD); end
        wait_neg(1);
        checks++; if (SEC_BCD !== 8'h08) begin
            errors++; $display("FAIL resume_full_tick: got %h expected 08", SEC_BCD); end
        KEY[0] = 1'b0;
        wait_neg(3);
        checks++; if (state !== 4'd4) begin
            errors++; $display("FAIL clear_from_timer: got %0d expected 4", state); end
        KEY[0] = 1'b1;
        wait_neg(1);
        checks++; if (state !== 4'd0 || MIN_BCD !== 8'h00 || SEC_BCD !== 8'h00) begin
            errors++; $display("FAIL clear_counts: got %0d %h:%h expected 0 00:00",
                               state, MIN_BCD, SEC_BCD); end
        wait_neg(1);
    endtask

    task automatic test_zero_start;
        load_preset(8'h00, 8'h00);
        KEY[2] = 1'b0;
        wait_neg(3);
        checks++; if (state !== 4'd5 || ALARM !== 1'b1) begin
            errors++; $display("FAIL zero_start: got %0d alarm=%b expected 5 alarm=1", state, ALARM);
        end
        KEY[2] = 1'b1;
        wait_neg(2);
        KEY[2] = 1'b0;
        wait_neg(3);
        checks++; if (state !== 4'd4) begin
            errors++; $display("FAIL flash_key2_reset: got %0d expected 4", state); end
        KEY[2] = 1'b1;
        wait_neg(3);
    endtask

    task automatic test_priority;
        KEY[0] = 1'b0;
        KEY[1] = 1'b0;
        wait_neg(3);
        checks++; if (state !== 4'd4) begin
            errors++; $display("FAIL priority_k0_k1: got %0d expected 4", state); end
        KEY = 3'b111;
        wait_neg(3);
    endtask

    task automatic test_hold;
        KEY[1] = 1'b0;
        wait_neg(3);
        checks++; if (state !== 4'd1) begin
            errors++; $display("FAIL hold_first: got %0d expected 1", state); end
        wait_neg(17);
        checks++; if (state !== 4'd1) begin
            errors++; $display("FAIL hold_single_event: got %0d expected 1", state); end
        KEY[1] = 1'b1;
        wait_neg(4);
        checks++; if (state !== 4'd1) begin
            errors++; $display("FAIL hold_release: got %0d expected 1", state); end
    endtask

    task automatic test_illegal;
        press(2'd1);
        force dut.state_q = 4'd7;
        #1;
        release dut.state_q;
        wait_neg(1);
        checks++; if (state !== 4'd4) begin
            errors++; $display("FAIL illegal_to_reset: got %0d expected 4", state); end
        wait_neg(1);
        checks++; if (state !== 4'd0) begin
            errors++; $display("FAIL illegal_then_set_sec: got %0d expected 0", state); end
    endtask

    task automatic test_async_reset;
        load_preset(8'h00, 8'h10);
        KEY[2] = 1'b0;
        wait_neg(3);
        KEY[2] = 1'b1;
        wait_neg(5);
        checks++; if (state !== 4'd2 || SEC_BCD !== 8'h09) begin
            errors++; $display("FAIL async_pre: got %0d %h expected 2 09", state, SEC_BCD); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (state !== 4'd4 || MIN_BCD !== 8'h00 || SEC_BCD !== 8'h00 || ALARM !== 1'b0)
        begin
            errors++; $display("FAIL async_reset: got %0d %h:%h alarm=%b expected 4 00:00 alarm=0",
                               state, MIN_BCD, SEC_BCD, ALARM); end
        wait_neg(2);
        rst_n = 1'b1;
        wait_neg(1);
        checks++; if (state !== 4'd0) begin
            errors++; $display("FAIL async_release: got %0d expected 0", state); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clamp();
        test_wrap_expiry();
        test_pause_resume();
        test_zero_start();
        test_priority();
        test_hold();
        test_illegal();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
